// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with saturating counters and F->D->E prediction pipe
// Optional statistics counters are built only when BP_STATS_EN is defined.
module branch_predictor #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PCF,
    output logic            PredTakenF,
    output logic [XLEN-1:0] PredTargetF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            FlushE,
    input  logic            ResolveE,
    input  logic [XLEN-1:0] PCE,
    input  logic            TakenE,
    input  logic [XLEN-1:0] TargetE,
    output logic            MispredictE,
    output logic [XLEN-1:0] RedirectPCE,
    output logic [31:0]     StatResolved,
    output logic [31:0]     StatMispredict
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDXW - 2;
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(2 ** (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'(2 ** (CTR_BITS - 1) - 1);

    logic                valid_q  [ENTRIES];
    logic                valid_d  [ENTRIES];
    logic [TAGW-1:0]     tag_q    [ENTRIES];
    logic [TAGW-1:0]     tag_d    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic [XLEN-1:0]     target_d [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d    [ENTRIES];

    logic            pred_taken_fd_q, pred_taken_fd_d;
    logic [XLEN-1:0] pred_target_fd_q, pred_target_fd_d;
    logic            pred_taken_de_q, pred_taken_de_d;
    logic [XLEN-1:0] pred_target_de_q, pred_target_de_d;

    logic [IDXW-1:0] idx_f, idx_e;
    logic [TAGW-1:0] tag_f, tag_e;
    logic            hit_f, hit_e;

    assign idx_f = PCF[IDXW+1:2];
    assign tag_f = PCF[XLEN-1:IDXW+2];
    assign idx_e = PCE[IDXW+1:2];
    assign tag_e = PCE[XLEN-1:IDXW+2];

    // Lookup reads only registered table state, so a same-cycle update is seen next cycle.
    assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign hit_e       = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign PredTakenF  = hit_f && ctr_q[idx_f][CTR_BITS-1];
    assign PredTargetF = hit_f ? target_q[idx_f] : PCF + XLEN'(4);

    always_comb begin
        pred_taken_fd_d  = pred_taken_fd_q;
        pred_target_fd_d = pred_target_fd_q;
        if (FlushD) begin
            pred_taken_fd_d  = 1'b0;
            pred_target_fd_d = '0;
        end else if (!StallD) begin
            pred_taken_fd_d  = PredTakenF;
            pred_target_fd_d = PredTargetF;
        end
        pred_taken_de_d  = FlushE ? 1'b0 : pred_taken_fd_q;
        pred_target_de_d = FlushE ? '0   : pred_target_fd_q;
    end

    assign MispredictE = ResolveE && ((TakenE != pred_taken_de_q) ||
                         (TakenE && pred_taken_de_q && (TargetE != pred_target_de_q)));
    assign RedirectPCE = TakenE ? TargetE : PCE + XLEN'(4);

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (ResolveE) begin
            if (hit_e) begin
                if (TakenE) begin
                    target_d[idx_e] = TargetE;
                    if (ctr_q[idx_e] != CTR_MAX) begin
                        ctr_d[idx_e] = ctr_q[idx_e] + CTR_BITS'(1);
                    end
                end else if (ctr_q[idx_e] != '0) begin
                    ctr_d[idx_e] = ctr_q[idx_e] - CTR_BITS'(1);
                end
            end else if (TakenE) begin
                valid_d[idx_e]  = 1'b1;
                tag_d[idx_e]    = tag_e;
                target_d[idx_e] = TargetE;
                ctr_d[idx_e]    = CTR_WT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
            pred_taken_fd_q  <= 1'b0;
            pred_target_fd_q <= '0;
            pred_taken_de_q  <= 1'b0;
            pred_target_de_q <= '0;
        end else begin
            valid_q          <= valid_d;
            tag_q            <= tag_d;
            target_q         <= target_d;
            ctr_q            <= ctr_d;
            pred_taken_fd_q  <= pred_taken_fd_d;
            pred_target_fd_q <= pred_target_fd_d;
            pred_taken_de_q  <= pred_taken_de_d;
            pred_target_de_q <= pred_target_de_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_resolved_q, stat_resolved_d;
    logic [31:0] stat_mispredict_q, stat_mispredict_d;

    always_comb begin
        stat_resolved_d   = stat_resolved_q + 32'(ResolveE);
        stat_mispredict_d = stat_mispredict_q + 32'(MispredictE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_resolved_q   <= '0;
            stat_mispredict_q <= '0;
        end else begin
            stat_resolved_q   <= stat_resolved_d;
            stat_mispredict_q <= stat_mispredict_d;
        end
    end

    assign StatResolved   = stat_resolved_q;
    assign StatMispredict = stat_mispredict_q;
`else
    assign StatResolved   = '0;
    assign StatMispredict = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - table-driven bench for branch_predictor (ENTRIES=16, CTR_BITS=2)
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        StallD, FlushD, FlushE, ResolveE;
    logic [31:0] PCE;
    logic        TakenE;
    logic [31:0] TargetE;
    logic        MispredictE;
    logic [31:0] RedirectPCE;
    logic [31:0] StatResolved, StatMispredict;

    branch_predictor #(.XLEN(32), .ENTRIES(16), .CTR_BITS(2)) dut (
        .clk(clk), .reset(reset), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
        .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE), .ResolveE(ResolveE), .PCE(PCE),
        .TakenE(TakenE), .TargetE(TargetE), .MispredictE(MispredictE), .RedirectPCE(RedirectPCE),
        .StatResolved(StatResolved), .StatMispredict(StatMispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pcf;
        logic        st, fd, fe, rs;
        logic [31:0] pce;
        logic        tk;
        logic [31:0] tg;
        logic        e_ptf;
        logic [31:0] e_ptg;
        logic        e_mis;
        logic [31:0] e_red;
    } vec_t;

    vec_t tbl [29];
    vec_t seq [5];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   exp_res = 0;
    int   exp_mis = 0;

    function automatic vec_t mk(input logic [31:0] pcf, input logic st, input logic fd,
                                input logic fe, input logic rs, input logic [31:0] pce,
                                input logic tk, input logic [31:0] tg, input logic ept,
                                input logic [31:0] epg, input logic emi, input logic [31:0] erd);
        vec_t v;
        v.pcf = pcf; v.st = st; v.fd = fd; v.fe = fe; v.rs = rs; v.pce = pce; v.tk = tk;
        v.tg = tg; v.e_ptf = ept; v.e_ptg = epg; v.e_mis = emi; v.e_red = erd;
        return v;
    endfunction

    function automatic logic [31:0] stat_exp(input int n);
`ifdef BP_STATS_EN
        return 32'(n);
`else
        return (n == -1) ? 32'hFFFF_FFFF : 32'h0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h", nm, act, exp);
        else pass_cnt++;
    endtask

    task automatic apply(input vec_t v, input string nm);
        PCF = v.pcf; StallD = v.st; FlushD = v.fd; FlushE = v.fe;
        ResolveE = v.rs; PCE = v.pce; TakenE = v.tk; TargetE = v.tg;
        #1;
        chk({nm, "_ptf"}, 32'(PredTakenF), 32'(v.e_ptf));
        chk({nm, "_ptg"}, PredTargetF, v.e_ptg);
        chk({nm, "_mis"}, 32'(MispredictE), 32'(v.e_mis));
        chk({nm, "_red"}, RedirectPCE, v.e_red);
        if (v.rs) exp_res++;
        if (v.e_mis) exp_mis++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //             pcf    st fd fe rs pce    tk tg      ptf ptg    mis red
        tbl[0]  = mk('h40,  0, 0, 0, 0, 'h0,  0, 'h0,   0, 'h44,  0, 'h4);
        tbl[1]  = mk('h40,  0, 0, 0, 0, 'h0,  0, 'h0,   0, 'h44,  0, 'h4);
        tbl[2]  = mk('h40,  0, 0, 0, 1, 'h40, 1, 'h100, 0, 'h44,  1, 'h100);
        tbl[3]  = mk('h40,  0, 0, 0, 0, 'h0,  0, 'h0,   1, 'h100, 0, 'h4);
        tbl[4]  = mk('h40,  0, 0, 0, 0, 'h0,  0, 'h0,   1, 'h100, 0, 'h4);
        tbl[5]  = mk('h40,  0, 0, 0, 1, 'h40, 0, 'h0,   1, 'h100, 1, 'h44);
        tbl[6]  = mk('h40,  0, 0, 0, 1, 'h40, 0, 'h0,   0, 'h100, 1, 'h44);
        tbl[7]  = mk('h40,  0, 0, 0, 1, 'h40, 0, 'h0,   0, 'h100, 1, 'h44);
        tbl[8]  = mk('h40,  0, 0, 0, 1, 'h40, 1, 'h100, 0, 'h100, 1, 'h100);
        tbl[9]  = mk('h40,  0, 0, 0, 0, 'h0,  0, 'h0,   0, 'h100, 0, 'h4);
        tbl[10] = mk('h80,  0, 0, 0, 1, 'h80, 1, 'h200, 0, 'h84,  1, 'h200);
        tbl[11] = mk('h40,  0, 0, 0, 0, 'h0,  0, 'h0,   0, 'h44,  0, 'h4);
        tbl[12] = mk('h80,  0, 0, 0, 0, 'h0,  0, 'h0,   1, 'h200, 0, 'h4);
        tbl[13] = mk('h80,  0, 0, 0, 0, 'h0,  0, 'h0,   1, 'h200, 0, 'h4);
        tbl[14] = mk('h80,  0, 0, 0, 1, 'h80, 1, 'h200, 1, 'h200, 0, 'h200);
        tbl[15] = mk('h80,  0, 0, 0, 1, 'h80, 1, 'h300, 1, 'h200, 1, 'h300);
        tbl[16] = mk('h80,  0, 0, 0, 1, 'h80, 0, 'h0,   1, 'h300, 1, 'h84);
        tbl[17] = mk('h80,  0, 0, 0, 0, 'h0,  0, 'h0,   1, 'h300, 0, 'h4);
        tbl[18] = mk('hC4,  0, 0, 0, 1, 'hC4, 0, 'h0,   0, 'hC8,  1, 'hC8);
        tbl[19] = mk('hC4,  0, 0, 0, 0, 'h0,  0, 'h0,   0, 'hC8,  0, 'h4);
        tbl[20] = mk('h80,  0, 0, 0, 0, 'h0,  0, 'h0,   1, 'h300, 0, 'h4);
        tbl[21] = mk('hC4,  1, 0, 0, 0, 'h0,  0, 'h0,   0, 'hC8,  0, 'h4);
        tbl[22] = mk('hC4,  1, 0, 0, 0, 'h0,  0, 'h0,   0, 'hC8,  0, 'h4);
        tbl[23] = mk('hC4,  0, 0, 1, 1, 'h80, 1, 'h300, 0, 'hC8,  0, 'h300);
        tbl[24] = mk('hC4,  0, 0, 0, 1, 'h80, 0, 'h0,   0, 'hC8,  0, 'h84);
        tbl[25] = mk('h80,  0, 0, 0, 0, 'h0,  0, 'h0,   1, 'h300, 0, 'h4);
        tbl[26] = mk('hC4,  1, 1, 0, 0, 'h0,  0, 'h0,   0, 'hC8,  0, 'h4);
        tbl[27] = mk('hC4,  0, 0, 0, 0, 'h0,  0, 'h0,   0, 'hC8,  0, 'h4);
        tbl[28] = mk('hC4,  0, 0, 0, 1, 'h80, 1, 'h300, 0, 'hC8,  1, 'h300);

        seq[0]  = mk('h300, 0, 0, 0, 1, 'h400, 0, 'h0,  0, 'h304, 0, 'h404);
        seq[1]  = mk('h300, 0, 0, 0, 1, 'h400, 1, 'h10, 0, 'h304, 1, 'h10);
        seq[2]  = mk('h300, 0, 0, 0, 1, 'h400, 0, 'h0,  0, 'h304, 0, 'h404);
        seq[3]  = mk('h300, 0, 0, 0, 1, 'h404, 1, 'h20, 0, 'h304, 1, 'h20);
        seq[4]  = mk('h300, 0, 0, 0, 1, 'h404, 0, 'h0,  0, 'h304, 0, 'h408);

        reset = 1'b1; PCF = '0; StallD = 0; FlushD = 0; FlushE = 0;
        ResolveE = 0; PCE = '0; TakenE = 0; TargetE = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_stat_res", StatResolved, stat_exp(0));
        chk("rst_stat_mis", StatMispredict, stat_exp(0));
        chk("rst_mis", 32'(MispredictE), 32'h0);

        for (int i = 0; i < 29; i++) apply(tbl[i], $sformatf("v%0d", i));
        chk("tbl_stat_res", StatResolved, stat_exp(exp_res));
        chk("tbl_stat_mis", StatMispredict, stat_exp(exp_mis));

        // Reset coincident with a taken resolve must not allocate.
        reset = 1'b1; ResolveE = 1; PCE = 'h200; TakenE = 1; TargetE = 'h500; PCF = 'h200;
        StallD = 0; FlushD = 0; FlushE = 0;
        @(posedge clk);
        #1;
        reset = 1'b0; ResolveE = 0; TakenE = 0; PCE = '0; TargetE = '0;
        exp_res = 0; exp_mis = 0;
        #1;
        chk("rr_ptf", 32'(PredTakenF), 32'h0);
        chk("rr_ptg", PredTargetF, 32'h204);
        chk("rr_mis", 32'(MispredictE), 32'h0);
        chk("rr_stat_res", StatResolved, stat_exp(0));
        chk("rr_stat_mis", StatMispredict, stat_exp(0));
        PCF = 'h80;
        #1;
        chk("rr_old_ptf", 32'(PredTakenF), 32'h0);
        chk("rr_old_ptg", PredTargetF, 32'h84);
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) apply(seq[i], $sformatf("s%0d", i));
        chk("st5_res", StatResolved, stat_exp(5));
        chk("st5_mis", StatMispredict, stat_exp(2));

        reset = 1'b1; ResolveE = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("st_clr_res", StatResolved, stat_exp(0));
        chk("st_clr_mis", StatMispredict, stat_exp(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
